// File: rtl/vram_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port synchronous VRAM (the 40x30 tile map) between the
// pixel renderer and the maze/player game logic. Display reads always win;
// game reads/writes are slotted into cycles with no display request, and by
// default only while the raster is in vertical blank so the visible frame
// never tears. Also emits a one-cycle frame-start pulse on the row wrap.
//
// Optional feature macro: VRAM_ANY_FREE_CYCLE_EN
//   defined   : the game may use any cycle without a display request
//   undefined : the game is restricted to rows >= VLINES (vertical blank)
//
// Parameters
//   AW      VRAM address width
//   DW      VRAM data width (tile code)
//   VLINES  first row index of vertical blank
//
// Ports
//   clk            system / pixel clock
//   rst_n          asynchronous reset, active low
//   i_row          current row from vga_sync
//   i_disp_req     renderer read request (no backpressure)
//   i_disp_addr    renderer read address
//   o_disp_rvalid  renderer read data valid (2 cycles after request)
//   o_disp_rdata   renderer read data
//   i_game_req     game request, held until o_game_ack
//   i_game_we      game write enable (1=write, 0=read)
//   i_game_addr    game address
//   i_game_wdata   game write data
//   o_game_ack     one-cycle completion pulse
//   o_game_rdata   game read data, valid with o_game_ack on reads
//   o_mem_en       VRAM enable
//   o_mem_we       VRAM write enable
//   o_mem_addr     VRAM address
//   o_mem_wdata    VRAM write data
//   i_mem_rdata    VRAM read data (1-cycle latency after o_mem_en)
//   o_frame_start  one-cycle pulse after i_row wraps from nonzero to 0
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int AW     = 11,
    parameter int DW     = 8,
    parameter int VLINES = 480
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [9:0]    i_row,
    input  logic          i_disp_req,
    input  logic [AW-1:0] i_disp_addr,
    output logic          o_disp_rvalid,
    output logic [DW-1:0] o_disp_rdata,
    input  logic          i_game_req,
    input  logic          i_game_we,
    input  logic [AW-1:0] i_game_addr,
    input  logic [DW-1:0] i_game_wdata,
    output logic          o_game_ack,
    output logic [DW-1:0] o_game_rdata,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_frame_start
);

    // Game access FSM encodings
    localparam logic [1:0] G_IDLE   = 2'd0;
    localparam logic [1:0] G_ISSUED = 2'd1;
    localparam logic [1:0] G_WAIT   = 2'd2;

    localparam logic [9:0] VBLANK_ROW = VLINES[9:0];

    logic [1:0] g_state;
    logic       g_we;         // direction of the in-flight game op
    logic       window_open;
    logic       game_grant;
    logic       disp_v1;      // display read issued to VRAM this cycle
    logic       disp_v2;      // display read data on i_mem_rdata this cycle
    logic [9:0] row_prev;

    // ------------------------------------------------------------------
    // Game access window
    // ------------------------------------------------------------------
`ifdef VRAM_ANY_FREE_CYCLE_EN
    assign window_open = 1'b1;
`else
    assign window_open = (i_row >= VBLANK_ROW);
`endif

    // Display requests have absolute priority; the game only takes a slot
    // from idle, so a request held through its own ack is not re-granted
    // while the previous op is still in flight.
    assign game_grant = (g_state == G_IDLE) && i_game_req && !i_disp_req && window_open;

    // ------------------------------------------------------------------
    // VRAM command register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else if (i_disp_req) begin
            o_mem_en   <= 1'b1;
            o_mem_we   <= 1'b0;
            o_mem_addr <= i_disp_addr;
        end else if (game_grant) begin
            o_mem_en    <= 1'b1;
            o_mem_we    <= i_game_we;
            o_mem_addr  <= i_game_addr;
            o_mem_wdata <= i_game_wdata;
        end else begin
            // Idle: address and write data deliberately hold their last value
            o_mem_en <= 1'b0;
            o_mem_we <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Display read pipeline: request -> command -> data, fixed 2 cycles
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_v1 <= 1'b0;
            disp_v2 <= 1'b0;
        end else begin
            disp_v1 <= i_disp_req;
            disp_v2 <= disp_v1;
        end
    end

    assign o_disp_rvalid = disp_v2;
    assign o_disp_rdata  = disp_v2 ? i_mem_rdata : '0;

    // ------------------------------------------------------------------
    // Game access FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_state <= G_IDLE;
            g_we    <= 1'b0;
        end else begin
            case (g_state)
                G_IDLE: begin
                    if (game_grant) begin
                        g_state <= G_ISSUED;
                        g_we    <= i_game_we;
                    end
                end
                G_ISSUED: g_state <= G_WAIT;
                G_WAIT:   g_state <= G_IDLE;
                default:  g_state <= G_IDLE;
            endcase
        end
    end

    // The ack cycle coincides with the VRAM data cycle, so read data is
    // passed straight through rather than registered a second time.
    assign o_game_ack   = (g_state == G_WAIT);
    assign o_game_rdata = (o_game_ack && !g_we) ? i_mem_rdata : '0;

    // ------------------------------------------------------------------
    // Frame start: row wrap detection. row_prev clears on reset, so the
    // first pulse only comes from a genuine nonzero -> 0 transition.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_prev      <= '0;
            o_frame_start <= 1'b0;
        end else begin
            row_prev      <= i_row;
            o_frame_start <= (row_prev != '0) && (i_row == '0);
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//
// Scoreboard bench for vram_arbiter. Stimulus pushes the expected VRAM
// commands, display read data, game acks and frame pulses (each tagged with
// the cycle it must appear in) into queues; a negedge monitor pops and
// compares whenever the DUT presents one of those outputs.
// Build with +define+VRAM_ANY_FREE_CYCLE_EN to exercise the any-free-cycle
// window instead of the vertical-blank window.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  i_row;
    logic        i_disp_req;
    logic [10:0] i_disp_addr;
    logic        o_disp_rvalid;
    logic [7:0]  o_disp_rdata;
    logic        i_game_req;
    logic        i_game_we;
    logic [10:0] i_game_addr;
    logic [7:0]  i_game_wdata;
    logic        o_game_ack;
    logic [7:0]  o_game_rdata;
    logic        o_mem_en;
    logic        o_mem_we;
    logic [10:0] o_mem_addr;
    logic [7:0]  o_mem_wdata;
    logic [7:0]  i_mem_rdata;
    logic        o_frame_start;

    vram_arbiter #(.AW(11), .DW(8), .VLINES(480)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_row         (i_row),
        .i_disp_req    (i_disp_req),
        .i_disp_addr   (i_disp_addr),
        .o_disp_rvalid (o_disp_rvalid),
        .o_disp_rdata  (o_disp_rdata),
        .i_game_req    (i_game_req),
        .i_game_we     (i_game_we),
        .i_game_addr   (i_game_addr),
        .i_game_wdata  (i_game_wdata),
        .o_game_ack    (o_game_ack),
        .o_game_rdata  (o_game_rdata),
        .o_mem_en      (o_mem_en),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_rdata   (i_mem_rdata),
        .o_frame_start (o_frame_start)
    );

    always #5 clk = ~clk;

    // Cycle counter: inputs driven 1ns after posedge k belong to cycle k,
    // outputs sampled at the following negedge also read as cycle k.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // VRAM model: unwritten locations read as addr[7:0] + 8'h40
    logic [7:0] ram [2048];
    bit         wr  [2048];
    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_we) begin
                ram[o_mem_addr] <= o_mem_wdata;
                wr[o_mem_addr]  <= 1'b1;
            end else begin
                i_mem_rdata <= wr[o_mem_addr] ? ram[o_mem_addr] : o_mem_addr[7:0] + 8'h40;
            end
        end
    end

    typedef struct {
        int unsigned cyc;
        logic        we;
        logic [10:0] addr;
        logic [7:0]  wdata;
    } cmd_t;

    typedef struct {
        int unsigned cyc;
        logic        chk;
        logic [7:0]  data;
    } rd_t;

    cmd_t        cmd_q  [$];
    rd_t         disp_q [$];
    rd_t         game_q [$];
    int unsigned frame_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_mem_en) begin
                if (cmd_q.size() == 0) begin
                    check("mem_unexpected", 64'(o_mem_addr), 64'hFFFF);
                end else begin
                    cmd_t c;
                    c = cmd_q.pop_front();
                    check("mem_cycle", 64'(cyc), 64'(c.cyc));
                    check("mem_we", 64'(o_mem_we), 64'(c.we));
                    check("mem_addr", 64'(o_mem_addr), 64'(c.addr));
                    if (c.we) check("mem_wdata", 64'(o_mem_wdata), 64'(c.wdata));
                end
            end
            if (o_disp_rvalid) begin
                if (disp_q.size() == 0) begin
                    check("disp_unexpected", 64'(o_disp_rdata), 64'hFFFF);
                end else begin
                    rd_t r;
                    r = disp_q.pop_front();
                    check("disp_cycle", 64'(cyc), 64'(r.cyc));
                    check("disp_rdata", 64'(o_disp_rdata), 64'(r.data));
                end
            end
            if (o_game_ack) begin
                if (game_q.size() == 0) begin
                    check("ack_unexpected", 64'(o_game_rdata), 64'hFFFF);
                end else begin
                    rd_t r;
                    r = game_q.pop_front();
                    check("ack_cycle", 64'(cyc), 64'(r.cyc));
                    if (r.chk) check("game_rdata", 64'(o_game_rdata), 64'(r.data));
                end
            end
            if (o_frame_start) begin
                if (frame_q.size() == 0) begin
                    check("frame_unexpected", 64'(cyc), 64'hFFFF_FFFF);
                end else begin
                    int unsigned f;
                    f = frame_q.pop_front();
                    check("frame_cycle", 64'(cyc), 64'(f));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp_read(input logic [10:0] addr, input logic [7:0] exp_data);
        i_disp_req  = 1'b1;
        i_disp_addr = addr;
        cmd_q.push_back('{cyc: cyc + 1, we: 1'b0, addr: addr, wdata: 8'h00});
        disp_q.push_back('{cyc: cyc + 2, chk: 1'b1, data: exp_data});
    endtask

    // Raise a game request and record its expectations, given the cycle in
    // which it is expected to be granted.
    task automatic game_issue(input logic we, input logic [10:0] addr, input logic [7:0] wdata,
                              input logic [7:0] exp_rdata, input int unsigned grant_cyc);
        i_game_req   = 1'b1;
        i_game_we    = we;
        i_game_addr  = addr;
        i_game_wdata = wdata;
        cmd_q.push_back('{cyc: grant_cyc + 1, we: we, addr: addr, wdata: wdata});
        game_q.push_back('{cyc: grant_cyc + 2, chk: !we, data: exp_rdata});
    endtask

    // Hold the request until ack, then drop it for the following cycle
    task automatic wait_ack();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (o_game_ack) seen = 1'b1;
        end
        if (!seen) check("ack_timeout", 64'd0, 64'd1);
        step();
        i_game_req = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        rst_n        = 1'b0;
        i_row        = 10'd0;
        i_disp_req   = 1'b0;
        i_disp_addr  = '0;
        i_game_req   = 1'b0;
        i_game_we    = 1'b0;
        i_game_addr  = '0;
        i_game_wdata = '0;

        repeat (3) step();
        check("reset_outputs",
              64'({o_disp_rvalid, o_disp_rdata, o_game_ack, o_game_rdata, o_mem_en,
                   o_mem_we, o_mem_addr, o_mem_wdata, o_frame_start}), 64'd0);
        rst_n = 1'b1;
        step();

        // Reset in the middle of a display read and a game request
        i_row = 10'd490;
        i_disp_req  = 1'b1;
        i_disp_addr = 11'd2;
        step();
        i_disp_req   = 1'b0;
        i_game_req   = 1'b1;
        i_game_we    = 1'b1;
        i_game_addr  = 11'd20;
        i_game_wdata = 8'hFF;
        #1 rst_n = 1'b0;
        #1 check("midop_reset_outputs",
                 64'({o_disp_rvalid, o_disp_rdata, o_game_ack, o_game_rdata, o_mem_en,
                      o_mem_we, o_mem_addr, o_mem_wdata, o_frame_start}), 64'd0);
        i_game_req = 1'b0;
        i_row      = 10'd0;
        repeat (2) step();
        rst_n = 1'b1;

        // Frame start: row held at 0 after reset gives no pulse; 520 -> 0 does
        repeat (3) step();
        i_row = 10'd519;
        step();
        i_row = 10'd520;
        step();
        i_row = 10'd0;
        frame_q.push_back(cyc + 1);
        step();
        step();
        i_row = 10'd100;
        repeat (3) step();

        // Display stream, 16 back-to-back reads
        for (int i = 0; i < 16; i++) begin
            disp_read(11'(i), 8'h40 + 8'(i));
            step();
        end
        i_disp_req = 1'b0;
        repeat (3) step();

`ifdef VRAM_ANY_FREE_CYCLE_EN
        // Game write in active video is granted at once
        i_row = 10'd100;
        game_issue(1'b1, 11'd12, 8'h3C, 8'h00, cyc);
        wait_ack();
        game_issue(1'b0, 11'd12, 8'h00, 8'h3C, cyc);
        wait_ack();
        repeat (2) step();
`else
        // Game write held off during active video, including row 479
        game_issue(1'b1, 11'd5, 8'hA5, 8'h00, 0);
        cmd_q.delete();
        game_q.delete();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) i_row = 10'd479;
            @(negedge clk);
            check("no_we_active_video", 64'(o_mem_we), 64'd0);
            step();
        end
        i_row = 10'd480;
        game_issue(1'b1, 11'd5, 8'hA5, 8'h00, cyc);
        wait_ack();
        game_issue(1'b0, 11'd5, 8'h00, 8'hA5, cyc);
        wait_ack();
        repeat (2) step();
`endif

        // Contention in vblank: display wins for two cycles, then the game read
        i_row = 10'd490;
        begin
            int unsigned k;
            k = cyc;
            disp_read(11'd3, 8'h43);
            i_game_req  = 1'b1;
            i_game_we   = 1'b0;
            i_game_addr = 11'd7;
            step();
            disp_read(11'd4, 8'h44);
            step();
            i_disp_req = 1'b0;
            game_issue(1'b0, 11'd7, 8'h00, 8'h47, k + 2);
            wait_ack();
        end
        repeat (2) step();

        // Held request: game read waits behind 7 display reads, 10 cycles held,
        // serviced exactly once (any extra access or ack hits an empty queue)
        i_row = 10'd500;
        begin
            int unsigned k;
            k = cyc;
            for (int i = 0; i < 7; i++) begin
                disp_read(11'd20 + 11'(i), 8'h54 + 8'(i));
                if (i == 0) begin
                    i_game_req  = 1'b1;
                    i_game_we   = 1'b0;
                    i_game_addr = 11'd9;
                end
                step();
            end
            i_disp_req = 1'b0;
            game_issue(1'b0, 11'd9, 8'h00, 8'h49, k + 7);
            wait_ack();
        end
        repeat (6) step();

        check("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
        check("disp_queue_drained", 64'(disp_q.size()), 64'd0);
        check("game_queue_drained", 64'(game_q.size()), 64'd0);
        check("frame_queue_drained", 64'(frame_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
